// File: rtl/im_sched_if.sv
// Request/connection bundle between the VC side of an input port and the
// IM scheduler. The requester (master) drives requests, directions and the
// per-CM blocked status; the scheduler (slave) returns acks, the crossbar
// configuration and the per-CM free flags.
interface im_sched_if #(
    parameter int VCN = 2,
    parameter int CMN = 2,
    parameter int SN  = 2
);
    logic [VCN-1:0]          vc_req;
    logic [VCN-1:0][SN-1:0]  vc_dir;
    logic [CMN-1:0][SN-1:0]  cm_blk;
    logic [VCN-1:0]          vc_ack;
    logic [CMN-1:0][VCN-1:0] cfg;
    logic [CMN-1:0]          cm_free;

    modport master (
        output vc_req, vc_dir, cm_blk,
        input  vc_ack, cfg, cm_free
    );

    modport slave (
        input  vc_req, vc_dir, cm_blk,
        output vc_ack, cfg, cm_free
    );
endinterface

// File: rtl/im_sched.sv
// IM crossbar scheduler: single-iteration iSLIP-style request/grant/accept
// matching of VCN virtual circuits onto CMN central modules, once per cycle.
// cfg, vc_ack and cm_free are all registered; eligibility is computed from
// the registered state so a CM freed at an edge is only reusable afterwards.
module im_sched #(
    parameter int VCN = 2,
    parameter int CMN = 2,
    parameter int SN  = 2
) (
    input  logic        clk,
    input  logic        rst,
    im_sched_if.slave   bus
);
    localparam int VPW = (VCN > 1) ? $clog2(VCN) : 1;
    localparam int CPW = (CMN > 1) ? $clog2(CMN) : 1;

    logic [VCN-1:0]          vc_req;
    logic [VCN-1:0][SN-1:0]  vc_dir;
    logic [CMN-1:0][SN-1:0]  cm_blk;

    logic [CMN-1:0][VCN-1:0] cfg_q, cfg_d;
    logic [VCN-1:0]          vc_ack_q, vc_ack_d;
    logic [CMN-1:0]          cm_free_q, cm_free_d;
    logic [CMN-1:0][VPW-1:0] g_ptr_q, g_ptr_d;
    logic [VCN-1:0][CPW-1:0] a_ptr_q, a_ptr_d;

    logic [VCN-1:0][CMN-1:0] elig;
    logic [CMN-1:0][VCN-1:0] grant;
    logic [VCN-1:0][CMN-1:0] accept;

    assign vc_req = bus.vc_req;
    assign vc_dir = bus.vc_dir;
    assign cm_blk = bus.cm_blk;

    assign bus.vc_ack  = vc_ack_q;
    assign bus.cfg     = cfg_q;
    assign bus.cm_free = cm_free_q;

    // Circular index base+k modulo n; base and k are both below n.
    function automatic int wrap_add(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? s - n : s;
    endfunction

    // Eligibility: waiting VC, free CM, and at least one wanted direction unblocked.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any
        // conditional update so no path leaves it holding a value (no latch).
        elig = '0;
        for (int i = 0; i < VCN; i++) begin
            for (int j = 0; j < CMN; j++) begin
                elig[i][j] = vc_req[i] & ~vc_ack_q[i] & cm_free_q[j]
                           & |(vc_dir[i] & ~cm_blk[j]);
            end
        end
    end

    // Grant: each CM picks the first eligible VC at or after its grant pointer.
    always_comb begin : grant_arb
        logic found;
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < CMN; j++) begin
            found = 1'b0;
            for (int k = 0; k < VCN; k++) begin
                for (int i = 0; i < VCN; i++) begin
                    if (!found && elig[i][j] &&
                        i == wrap_add(int'(g_ptr_q[j]), k, VCN)) begin
                        grant[j][i] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    // Accept: each granted VC picks the first granting CM at or after its accept pointer.
    always_comb begin : accept_arb
        logic found;
        accept = '0;
        found  = 1'b0;
        for (int i = 0; i < VCN; i++) begin
            found = 1'b0;
            for (int k = 0; k < CMN; k++) begin
                for (int j = 0; j < CMN; j++) begin
                    if (!found && grant[j][i] &&
                        j == wrap_add(int'(a_ptr_q[i]), k, CMN)) begin
                        accept[i][j] = 1'b1;
                        found        = 1'b1;
                    end
                end
            end
        end
    end

    // Next state: apply releases, then new matches and pointer updates; derive ack/free.
    always_comb begin
        cfg_d     = cfg_q;
        g_ptr_d   = g_ptr_q;
        a_ptr_d   = a_ptr_q;
        vc_ack_d  = '0;
        cm_free_d = '0;

        // A connected VC that dropped its request gives up its CM.
        for (int i = 0; i < VCN; i++) begin
            if (vc_ack_q[i] && !vc_req[i]) begin
                for (int j = 0; j < CMN; j++) begin
                    cfg_d[j][i] = 1'b0;
                end
            end
        end

        // Matches only touch free CMs and unconnected VCs, so they never
        // collide with a release in the same cycle.
        for (int i = 0; i < VCN; i++) begin
            for (int j = 0; j < CMN; j++) begin
                if (accept[i][j]) begin
                    cfg_d[j][i] = 1'b1;
                    g_ptr_d[j]  = VPW'(wrap_add(i, 1, VCN));
                    a_ptr_d[i]  = CPW'(wrap_add(j, 1, CMN));
                end
            end
        end

        for (int i = 0; i < VCN; i++) begin
            for (int j = 0; j < CMN; j++) begin
                vc_ack_d[i] = vc_ack_d[i] | cfg_d[j][i];
            end
        end
        for (int j = 0; j < CMN; j++) begin
            cm_free_d[j] = ~|cfg_d[j];
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            cfg_q     <= '0;
            vc_ack_q  <= '0;
            cm_free_q <= '1;
            g_ptr_q   <= '0;
            a_ptr_q   <= '0;
        end else begin
            cfg_q     <= cfg_d;
            vc_ack_q  <= vc_ack_d;
            cm_free_q <= cm_free_d;
            g_ptr_q   <= g_ptr_d;
            a_ptr_q   <= a_ptr_d;
        end
    end
endmodule

// File: tb/tb_im_sched.sv
// Directed bench for im_sched: one instance with two CMs, one with a single CM.
module tb_im_sched;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    im_sched_if #(.VCN(2), .CMN(2), .SN(2)) b2 ();
    im_sched_if #(.VCN(2), .CMN(1), .SN(2)) b1 ();

    im_sched #(.VCN(2), .CMN(2), .SN(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    im_sched #(.VCN(2), .CMN(1), .SN(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [3:0] cfg, input logic [1:0] ack,
                        input logic [1:0] free);
        check({tag, ".cfg"},  32'(b2.cfg),     32'(cfg));
        check({tag, ".ack"},  32'(b2.vc_ack),  32'(ack));
        check({tag, ".free"}, 32'(b2.cm_free), 32'(free));
    endtask

    task automatic chk1(input string tag, input logic [1:0] cfg, input logic [1:0] ack,
                        input logic free);
        check({tag, ".cfg"},  32'(b1.cfg),     32'(cfg));
        check({tag, ".ack"},  32'(b1.vc_ack),  32'(ack));
        check({tag, ".free"}, 32'(b1.cm_free), 32'(free));
    endtask

    initial begin
        logic [1:0] exp_win;
        checks = 0;
        errors = 0;

        // Reset held two cycles while both VCs request.
        rst       = 1'b1;
        b2.vc_req = 2'b11;
        b2.vc_dir = 4'b0101;
        b2.cm_blk = 4'b0000;
        b1.vc_req = 2'b00;
        b1.vc_dir = 4'b0101;
        b1.cm_blk = 2'b00;
        tick();
        chk2("rst_1", 4'b0000, 2'b00, 2'b11);
        tick();
        chk2("rst_2", 4'b0000, 2'b00, 2'b11);
        chk1("rst1_2", 2'b00, 2'b00, 1'b1);

        // Contention: both CMs grant VC0, VC0 takes CM0; VC1 gets CM1 next edge.
        rst = 1'b0;
        tick();
        chk2("cont_e1", 4'b0001, 2'b01, 2'b10);
        tick();
        chk2("cont_e2", 4'b1001, 2'b11, 2'b00);
        b2.vc_req = 2'b00;
        tick();
        chk2("cont_rel", 4'b0000, 2'b00, 2'b11);

        // Single request after reset, then a second one tests the accept pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2.vc_req = 2'b01;
        tick();
        chk2("single", 4'b0001, 2'b01, 2'b10);
        b2.vc_req = 2'b00;
        tick();
        chk2("single_rel", 4'b0000, 2'b00, 2'b11);
        b2.vc_req = 2'b01;
        tick();
        chk2("aptr_cm1", 4'b0100, 2'b01, 2'b01);
        b2.vc_req = 2'b00;
        tick();
        chk2("aptr_rel", 4'b0000, 2'b00, 2'b11);

        // Blocking: both CMs block direction 0; VC0 wants only direction 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2.cm_blk = 4'b0101;
        b2.vc_dir = 4'b0001;
        b2.vc_req = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("blk_wait.ack", 32'(b2.vc_ack), 32'(2'b00));
        end
        b2.cm_blk = 4'b0001;
        tick();
        chk2("blk_unblk", 4'b0100, 2'b01, 2'b01);

        // Re-block CM1 (held); VC1 waits with no direction at all.
        b2.cm_blk = 4'b0101;
        b2.vc_req = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk2("blk_hold", 4'b0100, 2'b01, 2'b01);
        end

        // VC1 switches to direction 1 while waiting: CM0 can serve it.
        b2.vc_dir = 4'b1001;
        tick();
        chk2("dir_change", 4'b0110, 2'b11, 2'b00);
        b2.vc_req = 2'b10;
        tick();
        chk2("rel_vc0", 4'b0010, 2'b10, 2'b10);
        b2.vc_req = 2'b00;

        // Single CM: release and reuse.
        b1.vc_req = 2'b01;
        tick();
        chk1("c1_conn0", 2'b01, 2'b01, 1'b0);
        b1.vc_req = 2'b11;
        tick();
        chk1("c1_vc1_wait", 2'b01, 2'b01, 1'b0);
        b1.vc_req = 2'b10;
        tick();
        chk1("c1_release", 2'b00, 2'b00, 1'b1);
        tick();
        chk1("c1_reuse", 2'b10, 2'b10, 1'b0);

        // VC1 releases while VC0 requests: CM reused the edge after.
        b1.vc_req = 2'b01;
        tick();
        chk1("c1_rel_vc1", 2'b00, 2'b00, 1'b1);
        tick();
        chk1("c1_conn0b", 2'b01, 2'b01, 1'b0);

        // Withdraw: VC1 requests then drops before it is ever served.
        b1.vc_req = 2'b11;
        tick();
        chk1("wd_wait", 2'b01, 2'b01, 1'b0);
        b1.vc_req = 2'b01;
        tick();
        chk1("wd_drop", 2'b01, 2'b01, 1'b0);
        b1.vc_req = 2'b00;
        tick();
        chk1("wd_rel", 2'b00, 2'b00, 1'b1);
        tick();
        chk1("wd_never", 2'b00, 2'b00, 1'b1);

        // Fairness: after reset both VCs keep requesting; winners alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_win = 2'b01;
        for (int r = 0; r < 6; r++) begin
            b1.vc_req = 2'b11;
            tick();
            check("fair_win.ack", 32'(b1.vc_ack), 32'(exp_win));
            b1.vc_req = 2'b11 & ~exp_win;
            tick();
            check("fair_rel.ack", 32'(b1.vc_ack), 32'(2'b00));
            exp_win = {exp_win[0], exp_win[1]};
        end

        // Reset in the middle of a connection clears it at that edge.
        b1.vc_req = 2'b11;
        tick();
        chk1("mid_conn", 2'b01, 2'b01, 1'b0);
        rst = 1'b1;
        tick();
        chk1("mid_rst", 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        b1.vc_req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
